// File: rtl/vga_frame_crc.sv
// Golden-frame capture: CRC-16/CCITT over one armed frame's active pixels, plus pixel/line counts.
// Optional hsync consistency check enabled by defining VGA_CRC_SYNC_CHECK_EN.
module vga_frame_crc #(
   parameter logic [15:0] CRC_INIT = 16'hFFFF,
   parameter int unsigned PIX_W    = 19,
   parameter int unsigned LINE_W   = 10
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_arm,
   input  logic              i_hblank,
   input  logic              i_vblank,
   input  logic              i_hsync_n,
   input  logic [5:0]        i_rgb,
   output logic              o_busy,
   output logic              o_done,
   output logic [15:0]       o_crc,
   output logic [PIX_W-1:0]  o_pix_count,
   output logic [LINE_W-1:0] o_line_count,
   output logic [7:0]        o_frame_count,
   output logic              o_err
);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_e;

   state_e              state_q, state_d;
   logic                vblank_q, vblank_d;
   logic                hblank_q, hblank_d;
   logic [15:0]         crc_q, crc_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [7:0]          frame_q, frame_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic sof, eof, active, hfall;

   assign sof    = vblank_q & ~i_vblank;
   assign eof    = ~vblank_q & i_vblank;
   assign active = ~i_hblank & ~i_vblank;
   assign hfall  = hblank_q & ~i_hblank & ~i_vblank;

   // Six serial CCITT steps unrolled, rgb[5] shifted in first.
   function automatic logic [15:0] crc16_6(input logic [15:0] c, input logic [5:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int unsigned i = 0; i < 6; i++) begin
         fb = r[15] ^ d[3'(5 - i)];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      vblank_d = i_vblank;
      hblank_d = i_hblank;
      crc_d    = crc_q;
      pix_d    = pix_q;
      line_d   = line_q;
      frame_d  = frame_q;
      case (state_q)
         IDLE: begin
            if (i_arm) state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (sof) begin
               crc_d   = CRC_INIT;
               pix_d   = '0;
               line_d  = '0;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (eof) begin
               state_d = DONE;
               frame_d = frame_q + 8'd1;
            end else begin
               if (active) begin
                  crc_d = crc16_6(crc_q, i_rgb);
                  if (pix_q != '1) pix_d = pix_q + PIX_W'(1);
               end
               if (hfall && line_q != '1) line_d = line_q + LINE_W'(1);
            end
         end
         DONE: begin
            if (i_arm) state_d = WAIT_SOF;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == WAIT_SOF) || (state_d == CAPTURE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         vblank_q <= 1'b0;
         hblank_q <= 1'b0;
         crc_q    <= CRC_INIT;
         pix_q    <= '0;
         line_q   <= '0;
         frame_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vblank_q <= vblank_d;
         hblank_q <= hblank_d;
         crc_q    <= crc_d;
         pix_q    <= pix_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_crc         = crc_q;
   assign o_pix_count   = pix_q;
   assign o_line_count  = line_q;
   assign o_frame_count = frame_q;

`ifdef VGA_CRC_SYNC_CHECK_EN
   logic              hsync_q, hsync_d;
   logic [LINE_W-1:0] hs_cnt_q, hs_cnt_d;
   logic              err_q, err_d;

   always_comb begin
      hsync_d  = i_hsync_n;
      hs_cnt_d = hs_cnt_q;
      err_d    = err_q;
      if (state_q == WAIT_SOF && sof) begin
         hs_cnt_d = '0;
         err_d    = 1'b0;
      end else if (state_q == CAPTURE) begin
         if (hsync_q && !i_hsync_n && hs_cnt_q != '1) hs_cnt_d = hs_cnt_q + LINE_W'(1);
         if (active && !i_hsync_n) err_d = 1'b1;
         if (eof && hs_cnt_q != line_q) err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hsync_q  <= 1'b1;
         hs_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         hsync_q  <= hsync_d;
         hs_cnt_q <= hs_cnt_d;
         err_q    <= err_d;
      end
   end

   assign o_err = err_q;
`else
   // hsync is only consumed by the sync check; the name keeps the lint unused-signal rule quiet.
   logic unused_hsync;
   assign unused_hsync = i_hsync_n;
   assign o_err        = 1'b0;
`endif

endmodule
